prbs_checker: RTL and testbench

Streaming PRBS checker placed downstream of the parallel PRBS word generator, on the receive side of the link. It consumes one DW-bit word per valid cycle and self-synchronises its local state to the incoming sequence. Once locked, it compares every word against its own prediction and reports per-word and accumulated bit-error counts. It also declares loss of lock after sustained corruption.

---
 rtl/prbs_checker.sv | 128 ++++++++++++
 tb/tb_prbs_checker.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to the incoming word stream, then
// free-runs its own prediction and reports per-word and accumulated bit errors.
module prbs_checker #(
    parameter int               POL_W      = 7,
    parameter logic [POL_W:0]   POL_MASK   = 8'hC0,
    parameter int               DW         = 16,
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 4,
    parameter int               BAD_BITS   = 4,
    parameter int               CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    output logic                     locked,
    output logic                     err_valid,
    output logic [$clog2(DW+1)-1:0]  err_bits,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         word_cnt
);

    localparam int EBW = $clog2(DW+1);
    localparam int MW  = $clog2(LOCK_CNT+1);
    localparam int BW  = $clog2(UNLOCK_CNT+1);

    localparam logic [MW-1:0]  LOCK_TH   = MW'(LOCK_CNT);
    localparam logic [BW-1:0]  UNLOCK_TH = BW'(UNLOCK_CNT);
    localparam logic [EBW-1:0] BAD_TH    = EBW'(BAD_BITS);

    typedef enum logic {SEARCH, LOCKED} fsm_t;

    fsm_t              fsm;
    logic [POL_W-1:0]  state;
    logic              has_seed;
    logic [MW-1:0]     match_cnt;
    logic [BW-1:0]     bad_cnt;

    logic [DW-1:0]     pred;
    logic [EBW-1:0]    pc;
    logic [POL_W-1:0]  seed;
    logic [MW-1:0]     match_next;
    logic [BW-1:0]     bad_next;
    logic [CNT_W:0]    err_sum;

    // Bit DW-1 of the word is oldest, so the chain runs from the MSB downward,
    // each new bit drawing its taps from the previous POL_W bits of the window.
    function automatic logic [DW-1:0] predict(input logic [POL_W-1:0] s);
        logic [POL_W+DW-1:0] x;
        x = {s, {DW{1'b0}}};
        for (int i = DW-1; i >= 0; i--)
            x[i] = ^(x[i +: POL_W+1] & POL_MASK);
        return x[DW-1:0];
    endfunction

    function automatic logic [EBW-1:0] popcount(input logic [DW-1:0] v);
        logic [EBW-1:0] n;
        n = '0;
        for (int i = 0; i < DW; i++)
            n = n + {{(EBW-1){1'b0}}, v[i]};
        return n;
    endfunction

    always_comb begin
        pred       = predict(state);
        pc         = popcount(in_data ^ pred);
        seed       = in_data[POL_W-1:0];
        match_next = (has_seed && (in_data == pred)) ? match_cnt + 1'b1 : '0;
        bad_next   = (pc >= BAD_TH) ? bad_cnt + 1'b1 : '0;
        err_sum    = {1'b0, err_cnt} + {{(CNT_W+1-EBW){1'b0}}, pc};
    end

    assign locked = (fsm == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= SEARCH;
            state     <= '0;
            has_seed  <= 1'b0;
            match_cnt <= '0;
            bad_cnt   <= '0;
            err_valid <= 1'b0;
            err_bits  <= '0;
            err_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            err_valid <= 1'b0;
            if (in_valid) begin
                case (fsm)
                    SEARCH: begin
                        state     <= seed;
                        has_seed  <= |seed;
                        match_cnt <= match_next;
                        if (match_next == LOCK_TH) begin
                            fsm     <= LOCKED;
                            bad_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on our own prediction so line errors never leak in.
                        state     <= pred[POL_W-1:0];
                        err_bits  <= pc;
                        err_valid <= 1'b1;
                        bad_cnt   <= bad_next;
                        if (bad_next == UNLOCK_TH) begin
                            fsm       <= SEARCH;
                            match_cnt <= '0;
                            state     <= seed;
                            has_seed  <= |seed;
                        end
                    end
                    default: fsm <= SEARCH;
                endcase
            end

            // clr takes priority over the contribution of a word accepted this cycle.
            if (clr) begin
                err_cnt  <= '0;
                word_cnt <= '0;
            end else if (in_valid && fsm == LOCKED) begin
                err_cnt  <= err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
                word_cnt <= (&word_cnt) ? word_cnt : word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker against a bit-serial
// reference of the x^7+x^6+1 sequence and the checker's lock/count rules.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        locked;
    logic        err_valid;
    logic [4:0]  err_bits;
    logic [31:0] err_cnt;
    logic [31:0] word_cnt;

    prbs_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err_valid (err_valid),
        .err_bits  (err_bits),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          fails   = 0;

    bit          m_locked;
    bit          m_has_seed;
    bit          m_ev;
    logic [6:0]  m_state;
    int          m_match;
    int          m_bad;
    logic [4:0]  m_eb;
    longint      m_ec;
    longint      m_wc;
    logic [6:0]  g_state;

    // Serial recurrence b[n] = b[n-6] ^ b[n-7], oldest bit first into the word MSB.
    function automatic logic [15:0] gen_word(input logic [6:0] s);
        bit          h[23];
        logic [15:0] w;
        for (int k = 0; k < 7; k++) h[k] = s[6-k];
        for (int n = 7; n < 23; n++) h[n] = h[n-6] ^ h[n-7];
        for (int k = 0; k < 16; k++) w[15-k] = h[7+k];
        return w;
    endfunction

    function automatic logic [15:0] next_clean();
        logic [15:0] w;
        w = gen_word(g_state);
        g_state = w[6:0];
        return w;
    endfunction

    function automatic logic [70:0] expv();
        return {m_locked, m_ev, m_eb, m_ec[31:0], m_wc[31:0]};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_has_seed = 0; m_ev = 0; m_state = '0;
        m_match = 0; m_bad = 0; m_eb = '0; m_ec = 0; m_wc = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic c);
        logic [15:0] p;
        int          pc;
        m_ev = 0;
        if (v) begin
            p = gen_word(m_state);
            if (!m_locked) begin
                if (m_has_seed && d == p) m_match++; else m_match = 0;
                m_state    = d[6:0];
                m_has_seed = (d[6:0] != 0);
                if (m_match == 4) begin m_locked = 1; m_bad = 0; end
            end else begin
                pc      = $countones(d ^ p);
                m_state = p[6:0];
                m_ev    = 1;
                m_eb    = 5'(pc);
                m_ec    = m_ec + pc;
                if (m_ec > 64'hFFFF_FFFF) m_ec = 64'hFFFF_FFFF;
                m_wc    = m_wc + 1;
                if (m_wc > 64'hFFFF_FFFF) m_wc = 64'hFFFF_FFFF;
                if (pc >= 4) m_bad++; else m_bad = 0;
                if (m_bad == 4) begin
                    m_locked   = 0;
                    m_match    = 0;
                    m_state    = d[6:0];
                    m_has_seed = (d[6:0] != 0);
                end
            end
        end
        if (c) begin m_ec = 0; m_wc = 0; end
    endtask

    // Presents one cycle of inputs, then samples 1 ns after the edge.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clr      = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        hard_reset();
        vectors++;
        if ({locked, err_valid, err_bits, err_cnt, word_cnt} !== 71'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: got %h want %h",
                     {locked, err_valid, err_bits, err_cnt, word_cnt}, 71'd0);
        end
    endtask

    task automatic test_lock();
        g_state = 7'h7F;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, next_clean(), 1'b0);
            vectors++;
            if ({locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
                fails++;
                $display("[TB] FAIL lock word %0d: got %h want %h", i,
                         {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
            end
            if (i == 4) begin
                vectors++;
                if (locked !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL lock_after_5th: got %b want 1", locked);
                end
            end
        end
        vectors++;
        if (word_cnt !== 32'd6 || err_cnt !== 32'd0) begin
            fails++;
            $display("[TB] FAIL lock_counts: got wc=%0d ec=%0d want wc=6 ec=0", word_cnt, err_cnt);
        end
    endtask

    task automatic test_single_error();
        applyStimulus(1'b1, next_clean() ^ 16'h0008, 1'b0);
        vectors++;
        if ({locked, err_valid, err_bits} !== {1'b1, 1'b1, 5'd1} ||
            {locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
            fails++;
            $display("[TB] FAIL single_error: got %h want %h",
                     {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
        end
        applyStimulus(1'b1, next_clean(), 1'b0);
        vectors++;
        if (err_bits !== 5'd0 || {locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
            fails++;
            $display("[TB] FAIL single_error_next: got %h want %h",
                     {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
        end
    endtask

    task automatic test_unlock();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, ~next_clean(), 1'b0);
            vectors++;
            if (err_bits !== 5'd16 || {locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
                fails++;
                $display("[TB] FAIL unlock word %0d: got %h want %h", i,
                         {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
            end
        end
        vectors++;
        if (locked !== 1'b0 || err_cnt !== 32'd64) begin
            fails++;
            $display("[TB] FAIL unlock_state: got locked=%b ec=%0d want locked=0 ec=64", locked, err_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, next_clean(), 1'b0);
            vectors++;
            if ({locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
                fails++;
                $display("[TB] FAIL relock word %0d: got %h want %h", i,
                         {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
            end
        end
        vectors++;
        if (locked !== 1'b1 || err_cnt !== 32'd64) begin
            fails++;
            $display("[TB] FAIL relock_state: got locked=%b ec=%0d want locked=1 ec=64", locked, err_cnt);
        end
    endtask

    task automatic test_clr_collision();
        applyStimulus(1'b1, next_clean() ^ 16'h0101, 1'b1);
        vectors++;
        if ({err_valid, err_bits, err_cnt, word_cnt} !== {1'b1, 5'd2, 32'd0, 32'd0} ||
            {locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
            fails++;
            $display("[TB] FAIL clr_collision: got %h want %h",
                     {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
        end
    endtask

    task automatic test_zero_stream();
        hard_reset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'h0000, 1'b0);
            vectors++;
            if (locked !== 1'b0 || err_valid !== 1'b0 ||
                {locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
                fails++;
                $display("[TB] FAIL zero_stream %0d: got %h want %h", i,
                         {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
            end
        end
    endtask

    task automatic test_gaps_random();
        int          burst = 0;
        logic [15:0] w;
        hard_reset();
        g_state = 7'($urandom_range(1, 127));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 25) begin
                applyStimulus(1'b0, 16'($urandom), ($urandom_range(0, 99) < 2));
            end else begin
                w = next_clean();
                if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(3, 6);
                if (burst > 0) begin
                    w = ~w;
                    burst--;
                end else if ($urandom_range(0, 99) < 15) begin
                    w = w ^ (16'h1 << $urandom_range(0, 15)) ^ (16'h1 << $urandom_range(0, 15));
                end
                applyStimulus(1'b1, w, ($urandom_range(0, 99) < 2));
            end
            vectors++;
            if ({locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
                fails++;
                $display("[TB] FAIL random cycle %0d: got %h want %h", i,
                         {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        hard_reset();
        g_state = 7'($urandom_range(1, 127));
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, next_clean(), 1'b0);
        vectors++;
        if (locked !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pre_reset_lock: got %b want 1", locked);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({locked, err_valid, err_bits, err_cnt, word_cnt} !== 71'd0) begin
            fails++;
            $display("[TB] FAIL async_reset: got %h want %h",
                     {locked, err_valid, err_bits, err_cnt, word_cnt}, 71'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, next_clean(), 1'b0);
            vectors++;
            if ({locked, err_valid, err_bits, err_cnt, word_cnt} !== expv()) begin
                fails++;
                $display("[TB] FAIL post_reset word %0d: got %h want %h", i,
                         {locked, err_valid, err_bits, err_cnt, word_cnt}, expv());
            end
        end
        vectors++;
        if (locked !== 1'b1) begin
            fails++;
            $display("[TB] FAIL post_reset_relock: got %b want 1", locked);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_unlock();
        test_clr_collision();
        test_zero_stream();
        test_gaps_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
